// File: rtl/bti_arb2_if.sv
// bus_trans_if: valid/ready request and response channels of the bus-transaction interface
interface bus_trans_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW+DW:0] req_pkt;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_pkt;
  modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
  modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

// File: rtl/bti_arb2.sv
// bti_arb2: round-robin 2:1 BTI arbiter, in-order ID FIFO routes responses to their issuer
module bti_arb2 #(
  parameter int BTI_AW   = 32,
  parameter int BTI_DW   = 32,
  parameter int MAX_OUTS = 2
) (
  input logic         clk,
  input logic         rst,
  bus_trans_if.slave  bti_m0,
  bus_trans_if.slave  bti_m1,
  bus_trans_if.master bti_s
);
  localparam int PW = MAX_OUTS > 1 ? $clog2(MAX_OUTS) : 1;
  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTS);
  logic                   rr_q, rr_d;
  logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [MAX_OUTS-1:0]    ids_q;
  logic                   gnt, full, empty, head, push, pop;
  logic [BTI_AW+BTI_DW:0] req_mux;
  logic [BTI_DW-1:0]      rsp_pkt;
  assign full    = cnt_q == FULL_CNT;
  assign empty   = cnt_q == '0;
  assign gnt     = bti_m1.req_vld & (~bti_m0.req_vld | rr_q);
  assign head    = ids_q[rp_q];
  assign req_mux = gnt ? bti_m1.req_pkt : bti_m0.req_pkt;
  assign rsp_pkt = bti_s.rsp_pkt;
  assign bti_s.req_vld  = (bti_m0.req_vld | bti_m1.req_vld) & ~full;
  assign bti_s.req_pkt  = req_mux;
  assign bti_m0.req_rdy = bti_m0.req_vld & ~gnt & bti_s.req_rdy & ~full;
  assign bti_m1.req_rdy = gnt & bti_s.req_rdy & ~full;
  // an empty FIFO blocks stray slave responses instead of forwarding them
  assign bti_s.rsp_rdy  = ~empty & (head ? bti_m1.rsp_rdy : bti_m0.rsp_rdy);
  assign bti_m0.rsp_vld = bti_s.rsp_vld & ~empty & ~head;
  assign bti_m1.rsp_vld = bti_s.rsp_vld & ~empty & head;
  assign bti_m0.rsp_pkt = rsp_pkt;
  assign bti_m1.rsp_pkt = rsp_pkt;
  assign push = bti_s.req_vld & bti_s.req_rdy;
  assign pop  = bti_s.rsp_vld & bti_s.rsp_rdy;
  always_comb begin
    rr_d  = push ? ~gnt : rr_q;
    wp_d  = push ? (wp_q == LAST ? '0 : wp_q + 1'b1) : wp_q;
    rp_d  = pop ? (rp_q == LAST ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) ids_q[wp_q] <= gnt;
  end
endmodule

// File: tb/tb_bti_arb2.sv
// tb_bti_arb2: directed scenarios with a scoreboard monitor checking slave requests and routed responses
module tb_bti_arb2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  bus_trans_if #(.AW(32), .DW(32)) m0 ();
  bus_trans_if #(.AW(32), .DW(32)) m1 ();
  bus_trans_if #(.AW(32), .DW(32)) s ();

  bti_arb2 #(.BTI_AW(32), .BTI_DW(32), .MAX_OUTS(2)) dut (
    .clk(clk), .rst(rst), .bti_m0(m0), .bti_m1(m1), .bti_s(s)
  );

  localparam logic [31:0] K = 32'h5A5A_0000;
  int pass_n = 0, total_n = 0, cyc = 0, m1_seen = 0;
  logic [31:0] mq0[$], mq1[$], pend[$], exp_req[$], exp0[$], exp1[$];
  int hs_cyc[$];
  logic s_rdy = 1'b1, rsp_en = 1'b1, m0_rdy = 1'b1, m1_rdy = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (mq0.size() == 0 && mq1.size() == 0 && pend.size() == 0 &&
          exp_req.size() == 0 && exp0.size() == 0 && exp1.size() == 0) return;
      tick();
    end
    total_n++;
    $display("FAIL drain_timeout: got req=%0d rsp0=%0d rsp1=%0d pending expected 0",
             exp_req.size(), exp0.size(), exp1.size());
  endtask

  // master/slave models plus scoreboard monitor; samples at negedge, drives 1ns after posedge
  initial begin
    logic hq, h0, h1, hr;
    logic [31:0] qa;
    m0.req_vld = 1'b0; m0.req_pkt = '0; m0.rsp_rdy = 1'b1;
    m1.req_vld = 1'b0; m1.req_pkt = '0; m1.rsp_rdy = 1'b1;
    s.req_rdy = 1'b1; s.rsp_vld = 1'b0; s.rsp_pkt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      hq = s.req_vld & s.req_rdy;
      h0 = m0.req_vld & m0.req_rdy;
      h1 = m1.req_vld & m1.req_rdy;
      hr = s.rsp_vld & s.rsp_rdy;
      qa = s.req_pkt[63:32];
      if (m1.rsp_vld) m1_seen++;
      if (hq) begin
        hs_cyc.push_back(cyc);
        if (exp_req.size() == 0) begin
          total_n++;
          $display("FAIL s_req_unexpected: got %h expected none", qa);
        end else chk("s_req_addr", qa, exp_req.pop_front());
      end
      if (m0.rsp_vld && m0.rsp_rdy) begin
        if (exp0.size() == 0) begin
          total_n++;
          $display("FAIL m0_rsp_unexpected: got %h expected none", m0.rsp_pkt);
        end else chk("m0_rsp_data", m0.rsp_pkt, exp0.pop_front());
      end
      if (m1.rsp_vld && m1.rsp_rdy) begin
        if (exp1.size() == 0) begin
          total_n++;
          $display("FAIL m1_rsp_unexpected: got %h expected none", m1.rsp_pkt);
        end else chk("m1_rsp_data", m1.rsp_pkt, exp1.pop_front());
      end
      @(posedge clk);
      #1;
      if (h0) void'(mq0.pop_front());
      if (h1) void'(mq1.pop_front());
      if (hr && pend.size() > 0) void'(pend.pop_front());
      if (hq) pend.push_back(qa);
      m0.req_vld = mq0.size() > 0;
      m0.req_pkt = mq0.size() > 0 ? {1'b0, mq0[0], 32'h0} : '0;
      m1.req_vld = mq1.size() > 0;
      m1.req_pkt = mq1.size() > 0 ? {1'b0, mq1[0], 32'h0} : '0;
      m0.rsp_rdy = m0_rdy;
      m1.rsp_rdy = m1_rdy;
      s.req_rdy  = s_rdy;
      s.rsp_vld  = rsp_en && pend.size() > 0;
      s.rsp_pkt  = pend.size() > 0 ? (pend[0] | K) : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_req_vld", 32'(s.req_vld), 0);
    chk("rst_s_rsp_rdy", 32'(s.rsp_rdy), 0);
    chk("rst_m0_rsp_vld", 32'(m0.rsp_vld), 0);
    chk("rst_m1_rsp_vld", 32'(m1.rsp_vld), 0);
    chk("rst_m0_req_rdy", 32'(m0.req_rdy), 0);
    chk("rst_m1_req_rdy", 32'(m1.req_rdy), 0);
    // single master back-to-back
    tick();
    hs_cyc.delete();
    m1_seen = 0;
    mq0 = '{32'h0, 32'h4, 32'h8};
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp0 = '{32'h5A5A_0000, 32'h5A5A_0004, 32'h5A5A_0008};
    drain(40);
    chk("s1_hs_count", 32'(hs_cyc.size()), 3);
    chk("s1_back_to_back", 32'(hs_cyc[2] - hs_cyc[0]), 2);
    chk("s1_m1_rsp_vld_seen", 32'(m1_seen), 0);
    // contention from reset: alternate m0, m1
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hs_cyc.delete();
    mq0 = '{32'h10, 32'h14};
    mq1 = '{32'h20, 32'h24};
    exp_req = '{32'h10, 32'h20, 32'h14, 32'h24};
    exp0 = '{32'h5A5A_0010, 32'h5A5A_0014};
    exp1 = '{32'h5A5A_0020, 32'h5A5A_0024};
    drain(40);
    chk("s2_back_to_back", 32'(hs_cyc[3] - hs_cyc[0]), 3);
    // full stall, then release one response
    tick();
    rsp_en = 1'b0;
    mq0 = '{32'h30, 32'h34, 32'h38};
    exp_req = '{32'h30, 32'h34, 32'h38};
    exp0 = '{32'h5A5A_0030, 32'h5A5A_0034, 32'h5A5A_0038};
    repeat (4) tick();
    @(negedge clk);
    chk("s3_full_s_req_vld", 32'(s.req_vld), 0);
    chk("s3_full_m0_req_vld", 32'(m0.req_vld), 1);
    chk("s3_full_m0_req_rdy", 32'(m0.req_rdy), 0);
    tick();
    rsp_en = 1'b1;
    tick();
    rsp_en = 1'b0;
    @(negedge clk);
    chk("s3_pop_s_rsp_rdy", 32'(s.rsp_rdy), 1);
    chk("s3_pop_no_bypass", 32'(s.req_vld), 0);
    tick();
    @(negedge clk);
    chk("s3_after_pop_s_req_vld", 32'(s.req_vld), 1);
    chk("s3_after_pop_m0_req_rdy", 32'(m0.req_rdy), 1);
    tick();
    rsp_en = 1'b1;
    drain(40);
    // routing with FIFO {1,0} and m1 backpressure
    tick();
    m1_rdy = 1'b0;
    mq1 = '{32'h40};
    exp_req = '{32'h40, 32'h44};
    exp1 = '{32'h5A5A_0040};
    exp0 = '{32'h5A5A_0044};
    tick();
    mq0 = '{32'h44};
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_s_rsp_vld", 32'(s.rsp_vld), 1);
      chk("s4_s_rsp_rdy", 32'(s.rsp_rdy), 0);
      chk("s4_m0_rsp_vld", 32'(m0.rsp_vld), 0);
      tick();
    end
    m1_rdy = 1'b1;
    drain(40);
    // steady push/pop at count 1, pointers wrap
    tick();
    hs_cyc.delete();
    mq1 = '{32'h50, 32'h54, 32'h58, 32'h5C, 32'h60};
    exp_req = '{32'h50, 32'h54, 32'h58, 32'h5C, 32'h60};
    exp1 = '{32'h5A5A_0050, 32'h5A5A_0054, 32'h5A5A_0058, 32'h5A5A_005C, 32'h5A5A_0060};
    drain(40);
    chk("s5_hs_count", 32'(hs_cyc.size()), 5);
    chk("s5_back_to_back", 32'(hs_cyc[4] - hs_cyc[0]), 4);
    // async reset with two outstanding, then stray responses
    tick();
    m0_rdy = 1'b0;
    mq0 = '{32'h70, 32'h74};
    exp_req = '{32'h70, 32'h74};
    repeat (4) tick();
    @(negedge clk);
    chk("s6_pre_m0_rsp_vld", 32'(m0.rsp_vld), 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_arst_s_req_vld", 32'(s.req_vld), 0);
    chk("s6_arst_s_rsp_rdy", 32'(s.rsp_rdy), 0);
    chk("s6_arst_m0_rsp_vld", 32'(m0.rsp_vld), 0);
    chk("s6_arst_m1_rsp_vld", 32'(m1.rsp_vld), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("s6_stray_s_rsp_vld", 32'(s.rsp_vld), 1);
      chk("s6_stray_s_rsp_rdy", 32'(s.rsp_rdy), 0);
      chk("s6_stray_m0_rsp_vld", 32'(m0.rsp_vld), 0);
      chk("s6_stray_m1_rsp_vld", 32'(m1.rsp_vld), 0);
      tick();
    end
    pend.delete();
    m0_rdy = 1'b1;
    drain(20);
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/bti_arb2.md
# bti_arb2

Two-master to one-slave arbiter for the bus-transaction interface (`bus_trans_if`). It sits directly upstream of a BTI slave such as the ROM adapter. It merges instruction-fetch and data-port requests onto that single slave with round-robin arbitration. It tracks up to `MAX_OUTS` outstanding requests in an in-order ID FIFO and routes each response back to the master that issued it.

## Interface
Parameters:
- `BTI_AW`, 32, BTI address width
- `BTI_DW`, 32, BTI data width
- `MAX_OUTS`, 2, maximum outstanding (accepted, not yet responded) transactions; ≥1

Ports:
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `bti_m0`  bus_trans_if.slave  —  master port 0 (fetch side)
- `bti_m1`  bus_trans_if.slave  —  master port 1 (data side)
- `bti_s`  bus_trans_if.master  —  downstream slave port

## Operation
- Arbitration state is one round-robin pointer `rr`: 0 favours m0, 1 favours m1.
- Grant rule: if only one master has `req_vld`, that master is granted. If both have it, the master favoured by `rr` is granted.
- Request path (combinational):
  - `bti_s.req_vld` = (m0.req_vld | m1.req_vld) & !full.
  - `bti_s.req_pkt` is the granted master's `req_pkt`.
  - Granted master's `req_rdy` = `bti_s.req_rdy` & !full. The non-granted master's `req_rdy` = 0.
- On a downstream request handshake (`bti_s.req_vld & bti_s.req_rdy`):
  - Push the granted ID (0/1) into the order FIFO.
  - Set `rr` to the opposite of the granted ID.
- Order FIFO:
  - `MAX_OUTS` entries of 1 bit, with read/write pointers that wrap modulo `MAX_OUTS`.
  - Occupancy counter is `$clog2(MAX_OUTS+1)` bits wide.
  - full = (count == MAX_OUTS); empty = (count == 0).
- Response path (combinational, in order):
  - With head ID h: `bti_mh.rsp_vld` = `bti_s.rsp_vld` & !empty, and `bti_mh.rsp_pkt` = `bti_s.rsp_pkt`.
  - The other master's `rsp_vld` = 0.
  - `bti_s.rsp_rdy` = `bti_mh.rsp_rdy` & !empty.
- On a downstream response handshake, pop the FIFO head.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- When full, requests stall even if a pop occurs the same cycle; there is no full-bypass.
- `bti_s.rsp_vld` while the FIFO is empty is a slave protocol error. It is not forwarded: `bti_s.rsp_rdy` = 0.
- A master holding `req_vld` without grant keeps waiting. Round-robin guarantees it is granted at the next downstream request handshake.

## Timing
- Request latency is zero cycles: a granted request is presented on `bti_s` in the same cycle as on `bti_mX`.
- Response latency is zero cycles: the slave response appears on the owning master in the same cycle.
- Throughput is one request per cycle while not full. Back-to-back alternation happens when both masters request continuously.
- Reset (async assert, sync to state):
  - `rr` = 0, FIFO pointers = 0, count = 0.
  - Resulting outputs: `bti_s.req_vld` = 0 until a master requests; `bti_s.rsp_rdy` = 0; both masters' `rsp_vld` = 0.
  - Masters' `req_rdy` = 0 while their `req_vld` = 0.
- Reset mid-transaction discards all outstanding IDs. Responses arriving after reset are blocked by the empty-FIFO rule.

## Test plan
- Single master, `MAX_OUTS`=2, slave always ready with 1-cycle response: m0 issues reads 0x0, 0x4, 0x8 back-to-back -> three `bti_s` request handshakes on consecutive cycles; responses delivered to m0 only, in order; m1 `rsp_vld` stays 0.
- Contention: m0 and m1 both hold `req_vld` from reset -> grants alternate m0, m1, m0, m1; `rr` toggles on each handshake; neither master waits more than one grant.
- Full stall, `MAX_OUTS`=2: slave holds `rsp_vld`=0 -> after 2 request handshakes `bti_s.req_vld`=0 and granted `req_rdy`=0. Releasing one response -> a request is accepted the next cycle, not the same cycle.
- Response routing under backpressure: FIFO holds IDs {1,0}, m1 `rsp_rdy`=0 for 3 cycles -> `bti_s.rsp_rdy`=0 for those cycles; m0 sees no `rsp_vld`. When m1 takes the response, the next response goes to m0.
- Simultaneous push/pop at count=1 -> count stays 1, pointers wrap correctly over 2×`MAX_OUTS` transactions.
- Async reset asserted with 2 outstanding -> outputs reach reset values immediately. A stray `bti_s.rsp_vld` after reset -> `bti_s.rsp_rdy`=0 and no master `rsp_vld`.
